// File: rtl/tb_periph_pkg.sv
// Shared offsets, magic defaults and status-word helpers for the testbench status peripheral.
package tb_periph_pkg;

  localparam logic [7:0] OFS_PRINT      = 8'h00;
  localparam logic [7:0] OFS_TEST_STAT  = 8'h04;
  localparam logic [7:0] OFS_EXIT       = 8'h08;
  localparam logic [7:0] OFS_TIMER_CTRL = 8'h0C;
  localparam logic [7:0] OFS_TIMER_CNT  = 8'h10;
  localparam logic [7:0] OFS_FIFO_STAT  = 8'h14;

  localparam logic [31:0] PASS_MAGIC_DEF = 32'd123456789;
  localparam logic [31:0] FAIL_MAGIC_DEF = 32'd1;

  localparam int unsigned STAT_FULL_BIT  = 16;
  localparam int unsigned STAT_EMPTY_BIT = 17;
  localparam int unsigned TIMER_EN_BIT   = 0;
  localparam int unsigned TIMER_CLR_BIT  = 1;

  typedef enum logic [2:0] {
    REG_PRINT,
    REG_TEST_STAT,
    REG_EXIT,
    REG_TIMER_CTRL,
    REG_TIMER_CNT,
    REG_FIFO_STAT,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_ofs(input logic [7:0] addr);
    reg_sel_e sel;
    case ({addr[7:2], 2'b00})
      OFS_PRINT:      sel = REG_PRINT;
      OFS_TEST_STAT:  sel = REG_TEST_STAT;
      OFS_EXIT:       sel = REG_EXIT;
      OFS_TIMER_CTRL: sel = REG_TIMER_CTRL;
      OFS_TIMER_CNT:  sel = REG_TIMER_CNT;
      OFS_FIFO_STAT:  sel = REG_FIFO_STAT;
      default:        sel = REG_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] fifo_stat_word(input logic [15:0] level,
                                                 input logic        full,
                                                 input logic        empty);
    logic [31:0] w;
    w                 = 32'd0;
    w[15:0]           = level;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    return w;
  endfunction

endpackage

// File: rtl/tb_char_fifo.sv
// 8-bit synchronous character FIFO with fill level; pushes when full and pops when empty are dropped.
module tb_char_fifo
  import tb_periph_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == LW'(0));
  assign level_o   = level_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Pointer and level update; DEPTH is a power of two so pointers wrap by overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tb_status_periph.sv
// Memory-mapped bench peripheral: stdout FIFO, pass/fail/exit indications and a free-running cycle timer.
module tb_status_periph
  import tb_periph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEF,
  parameter logic [31:0] FAIL_MAGIC = FAIL_MAGIC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [7:0]  data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  input  logic        stdout_ready_i,
  output logic [7:0]  stdout_data_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e          sel_s;
  logic              print_push_req_s;
  logic              gnt_s;
  logic              wr_s;
  logic              rd_s;
  logic              timer_clr_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  logic [LVL_W-1:0]  fifo_level_s;
  logic [31:0]       rdata_mux_s;
  logic [2:0]        unused_be_s;

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        passed_q, passed_d;
  logic        failed_q, failed_d;
  logic        exit_valid_q, exit_valid_d;
  logic [31:0] exit_value_q, exit_value_d;
  logic        timer_en_q, timer_en_d;
  logic [31:0] timer_q, timer_d;

  assign sel_s            = decode_ofs(data_addr_i);
  assign unused_be_s      = data_be_i[3:1];
  assign print_push_req_s = data_req_i & data_we_i & (sel_s == REG_PRINT) & data_be_i[0];
  // Stall uses the registered full flag, so a same-cycle pop does not free a slot.
  assign gnt_s            = data_req_i & ~(print_push_req_s & fifo_full_s);
  assign wr_s             = gnt_s & data_we_i;
  assign rd_s             = gnt_s & ~data_we_i;
  assign timer_clr_s      = wr_s & (sel_s == REG_TIMER_CTRL) & data_wdata_i[TIMER_CLR_BIT];
  assign fifo_pop_s       = stdout_ready_i & ~fifo_empty_s;

  tb_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_s & print_push_req_s),
    .data_i  (data_wdata_i[7:0]),
    .pop_i   (fifo_pop_s),
    .data_o  (stdout_data_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  // Read data selection, sampled into the response register at grant.
  always_comb begin
    rdata_mux_s = 32'd0;
    case (sel_s)
      REG_EXIT:       rdata_mux_s = exit_value_q;
      REG_TIMER_CTRL: rdata_mux_s = {31'd0, timer_en_q};
      REG_TIMER_CNT:  rdata_mux_s = timer_q;
      REG_FIFO_STAT:  rdata_mux_s = fifo_stat_word(16'(fifo_level_s), fifo_full_s, fifo_empty_s);
      default:        rdata_mux_s = 32'd0;
    endcase
  end

  // Next-state for response, indication pulses, exit code and timer.
  always_comb begin
    rvalid_d     = gnt_s;
    rdata_d      = 32'd0;
    passed_d     = 1'b0;
    failed_d     = 1'b0;
    exit_valid_d = 1'b0;
    exit_value_d = exit_value_q;
    timer_en_d   = timer_en_q;
    timer_d      = timer_q;

    if (rd_s) begin
      rdata_d = rdata_mux_s;
    end else begin
      rdata_d = 32'd0;
    end

    if (wr_s) begin
      case (sel_s)
        REG_TEST_STAT: begin
          if (data_wdata_i == PASS_MAGIC) begin
            passed_d = 1'b1;
          end else if (data_wdata_i == FAIL_MAGIC) begin
            failed_d = 1'b1;
          end else begin
            passed_d = 1'b0;
            failed_d = 1'b0;
          end
        end
        REG_EXIT: begin
          exit_value_d = data_wdata_i;
          exit_valid_d = 1'b1;
        end
        REG_TIMER_CTRL: begin
          timer_en_d = data_wdata_i[TIMER_EN_BIT];
        end
        default: begin
          exit_value_d = exit_value_q;
        end
      endcase
    end else begin
      exit_value_d = exit_value_q;
    end

    // Clear wins over increment; the enable change takes effect from the next cycle.
    if (timer_clr_s) begin
      timer_d = 32'd0;
    end else if (timer_en_q) begin
      timer_d = timer_q + 32'd1;
    end else begin
      timer_d = timer_q;
    end
  end

  // Register bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= 32'd0;
      timer_en_q   <= 1'b0;
      timer_q      <= 32'd0;
    end else begin
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
      timer_en_q   <= timer_en_d;
      timer_q      <= timer_d;
    end
  end

  assign data_gnt_o     = gnt_s;
  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign stdout_valid_o = ~fifo_empty_s;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_tb_status_periph.sv
// Randomised scoreboard bench for tb_status_periph against a queue/array-level model of its register map.
module tb_tb_status_periph;

  localparam int          DEPTH    = 16;
  localparam logic [31:0] MAG_PASS = 32'd123456789;
  localparam logic [31:0] MAG_FAIL = 32'd1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [7:0]  data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        stdout_valid_o;
  logic        stdout_ready_i;
  logic [7:0]  stdout_data_o;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;

  tb_status_periph #(
    .FIFO_DEPTH (DEPTH),
    .PASS_MAGIC (MAG_PASS),
    .FAIL_MAGIC (MAG_FAIL)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .stdout_valid_o (stdout_valid_o),
    .stdout_ready_i (stdout_ready_i),
    .stdout_data_o  (stdout_data_o),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] lo;
    logic [31:0] span;
    int          due;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [7:0]  m_chars[$];
  bit          pass_at[int];
  bit          fail_at[int];
  bit          exitv_at[int];
  logic [31:0] m_exit;
  bit          m_ten;
  logic [31:0] m_tval;
  int          m_tref;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void chk_win(string nm, logic [31:0] act, logic [31:0] lo, logic [31:0] span);
    checks++;
    if ($isunknown(act) || ((act - lo) > span)) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h..%0h (cycle %0d)", nm, act, lo, lo + span, cyc);
    end
  endfunction

  // Timer value held after clock edge d.
  function automatic logic [31:0] m_timer(int d);
    return m_tval + (m_ten ? 32'(d - m_tref) : 32'd0);
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_chars.delete();
    pass_at.delete();
    fail_at.delete();
    exitv_at.delete();
    m_exit = 32'd0;
    m_ten  = 1'b0;
    m_tval = 32'd0;
    m_tref = 0;
  endfunction

  // Apply the architectural effect of an access granted at cycle c (accepted on edge c+1).
  function automatic void model_grant(logic we, logic [7:0] addr, logic [3:0] be, logic [31:0] wd, int c);
    logic [7:0]  a;
    logic [31:0] exp;
    logic [31:0] span;
    logic [31:0] v;
    int          sz;
    a    = {addr[7:2], 2'b00};
    exp  = 32'd0;
    span = 32'd0;
    sz   = m_chars.size();
    if (!we) begin
      if (a == 8'h08) exp = m_exit;
      else if (a == 8'h0C) exp = {31'd0, m_ten};
      else if (a == 8'h10) begin
        exp  = m_timer(c) - 32'd2;
        span = 32'd4;
      end else if (a == 8'h14)
        exp = 32'(sz) | ((sz == DEPTH) ? 32'h0001_0000 : 32'd0) | ((sz == 0) ? 32'h0002_0000 : 32'd0);
      else exp = 32'd0;
    end else begin
      if (a == 8'h00 && be[0]) m_chars.push_back(wd[7:0]);
      else if (a == 8'h04 && wd == MAG_PASS) pass_at[c + 1] = 1'b1;
      else if (a == 8'h04 && wd == MAG_FAIL) fail_at[c + 1] = 1'b1;
      else if (a == 8'h08) begin
        m_exit         = wd;
        exitv_at[c + 1] = 1'b1;
      end else if (a == 8'h0C) begin
        v      = wd[1] ? 32'd0 : m_timer(c + 1);
        m_tval = v;
        m_tref = c + 1;
        m_ten  = wd[0];
      end
    end
    sb.push_back('{$sformatf("%s@%02h", we ? "wr" : "rd", addr), exp, span, c + 1});
  endfunction

  task automatic monitor_step();
    exp_t e;
    if (rst_ni === 1'b1) begin
      if (data_rvalid_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("rvalid_spurious", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk_win({e.name, "_rdata"}, data_rdata_o, e.lo, e.span);
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk({e.name, "_rvalid"}, {31'd0, data_rvalid_o}, 32'd1);
      end
      chk("tests_passed", {31'd0, tests_passed_o}, {31'd0, pass_at.exists(cyc)});
      chk("tests_failed", {31'd0, tests_failed_o}, {31'd0, fail_at.exists(cyc)});
      chk("exit_valid", {31'd0, exit_valid_o}, {31'd0, exitv_at.exists(cyc)});
      if (stdout_valid_o === 1'b1 && stdout_ready_i === 1'b1) begin
        if (m_chars.size() == 0) chk("stdout_spurious", {24'd0, stdout_data_o}, 32'hFFFF_FFFF);
        else chk("stdout_data", {24'd0, stdout_data_o}, {24'd0, m_chars.pop_front()});
      end
    end
  endtask

  task automatic issue(input logic we, input logic [7:0] addr, input logic [3:0] be, input logic [31:0] wd);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wd;
    if (!we && {addr[7:2], 2'b00} == 8'h14) stdout_ready_i = 1'b0;
  endtask

  task automatic wait_grant(output int gc);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    gc  = -1;
    while (!got && n < 50) begin
      @(negedge clk_i);
      if (data_gnt_o === 1'b1) got = 1'b1;
      else n++;
    end
    if (got) begin
      gc = cyc;
      model_grant(data_we_i, data_addr_i, data_be_i, data_wdata_i, gc);
    end else begin
      chk("gnt_timeout", 32'd0, 32'd1);
    end
    @(posedge clk_i);
    #1;
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    data_be_i  = 4'h0;
  endtask

  task automatic access(input logic we, input logic [7:0] addr, input logic [3:0] be, input logic [31:0] wd);
    int gc;
    issue(we, addr, be, wd);
    wait_grant(gc);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gc;
    int          op;
    logic [7:0]  ra;
    logic [31:0] wd;
    data_req_i     = 1'b0;
    data_we_i      = 1'b0;
    data_be_i      = 4'h0;
    data_addr_i    = 8'h00;
    data_wdata_i   = 32'd0;
    stdout_ready_i = 1'b0;
    rst_ni         = 1'b0;
    model_reset();
    fork
      forever begin
        @(negedge clk_i);
        monitor_step();
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    chk("rst_stdout_valid", {31'd0, stdout_valid_o}, 32'd0);
    chk("rst_pulses", {29'd0, tests_passed_o, tests_failed_o, exit_valid_o}, 32'd0);
    chk("rst_exit_value", exit_value_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycles(1);

    // Two printed characters drain in order
    stdout_ready_i = 1'b1;
    access(1'b1, 8'h00, 4'hF, 32'h41);
    access(1'b1, 8'h00, 4'hF, 32'h42);
    access(1'b1, 8'h00, 4'hE, 32'h43);
    access(1'b0, 8'h00, 4'hF, 32'd0);
    cycles(5);
    chk("t1_drained", 32'(m_chars.size()), 32'd0);

    // Fill to full with the consumer stalled, then free one slot
    stdout_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) access(1'b1, 8'h00, 4'h1, 32'h60 + 32'(i));
    access(1'b0, 8'h14, 4'hF, 32'd0);
    issue(1'b1, 8'h00, 4'h1, 32'h7A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("gnt_when_full", {31'd0, data_gnt_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    stdout_ready_i = 1'b1;
    @(negedge clk_i);
    chk("gnt_full_pop_same_cycle", {31'd0, data_gnt_o}, 32'd0);
    @(posedge clk_i);
    #1;
    stdout_ready_i = 1'b0;
    wait_grant(gc);
    access(1'b0, 8'h14, 4'hF, 32'd0);
    stdout_ready_i = 1'b1;
    cycles(DEPTH + 4);
    chk("t2_drained", 32'(m_chars.size()), 32'd0);
    access(1'b0, 8'h14, 4'hF, 32'd0);

    // Test status and exit
    access(1'b1, 8'h04, 4'hF, MAG_PASS);
    access(1'b1, 8'h04, 4'hF, MAG_FAIL);
    access(1'b1, 8'h04, 4'hF, 32'd5);
    access(1'b1, 8'h08, 4'hF, 32'h2A);
    @(negedge clk_i);
    chk("exit_value_held", exit_value_o, 32'h2A);
    @(posedge clk_i);
    #1;
    access(1'b0, 8'h08, 4'hF, 32'd0);

    // Timer: count, clear, then wrap from a preloaded value
    access(1'b1, 8'h0C, 4'hF, 32'd1);
    cycles(99);
    access(1'b0, 8'h10, 4'hF, 32'd0);
    access(1'b1, 8'h0C, 4'hF, 32'd3);
    cycles(3);
    access(1'b0, 8'h10, 4'hF, 32'd0);
    access(1'b0, 8'h0C, 4'hF, 32'd0);
    access(1'b1, 8'h10, 4'hF, 32'd0);
    access(1'b1, 8'h0C, 4'hF, 32'd0);
    @(negedge clk_i);
    force dut.timer_q = 32'hFFFF_FFFE;
    @(posedge clk_i);
    #1;
    release dut.timer_q;
    m_tval = 32'hFFFF_FFFE;
    access(1'b0, 8'h10, 4'hF, 32'd0);
    access(1'b1, 8'h0C, 4'hF, 32'd1);
    cycles(5);
    access(1'b0, 8'h10, 4'hF, 32'd0);
    access(1'b1, 8'h0C, 4'hF, 32'd0);

    // Randomised register traffic
    for (int it = 0; it < 200; it++) begin
      stdout_ready_i = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 6));
      case (op)
        0: begin
          if (m_chars.size() >= DEPTH - 1) stdout_ready_i = 1'b1;
          access(1'b1, 8'h00 | 8'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
        end
        1: begin
          wd = ($urandom_range(0, 2) == 0) ? MAG_PASS : (($urandom_range(0, 1) == 0) ? MAG_FAIL : $urandom);
          access(1'b1, 8'h04, 4'hF, wd);
        end
        2: access(1'b1, 8'h08, 4'hF, $urandom);
        3: access(1'b1, 8'h0C, 4'hF, 32'($urandom_range(0, 3)));
        4: begin
          ra = 8'h18 + 8'(4 * $urandom_range(0, 57));
          access(1'b1, ($urandom_range(0, 1) == 0) ? ra : 8'h10 + 8'(4 * $urandom_range(0, 1)), 4'hF, $urandom);
        end
        default: begin
          ra = ($urandom_range(0, 6) == 6) ? 8'h18 + 8'(4 * $urandom_range(0, 57)) : 8'(4 * $urandom_range(0, 5));
          access(1'b0, ra | 8'($urandom_range(0, 3)), 4'hF, 32'd0);
        end
      endcase
      if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, 3)));
    end
    stdout_ready_i = 1'b1;
    cycles(DEPTH + 4);
    chk("rand_drained", 32'(m_chars.size()), 32'd0);

    // Reset with a half-full FIFO and a read in flight
    stdout_ready_i = 1'b0;
    access(1'b1, 8'h0C, 4'hF, 32'd1);
    for (int i = 0; i < DEPTH / 2; i++) access(1'b1, 8'h00, 4'hF, 32'h30 + 32'(i));
    access(1'b1, 8'h08, 4'hF, 32'h55);
    issue(1'b0, 8'h14, 4'hF, 32'd0);
    @(negedge clk_i);
    chk("rst_read_gnt", {31'd0, data_gnt_o}, 32'd1);
    #1;
    rst_ni     = 1'b0;
    data_req_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    chk("midrst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    chk("midrst_stdout_valid", {31'd0, stdout_valid_o}, 32'd0);
    chk("midrst_pulses", {29'd0, tests_passed_o, tests_failed_o, exit_valid_o}, 32'd0);
    chk("midrst_exit_value", exit_value_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycles(1);
    access(1'b0, 8'h14, 4'hF, 32'd0);
    access(1'b0, 8'h10, 4'hF, 32'd0);
    access(1'b0, 8'h0C, 4'hF, 32'd0);

    cycles(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
